mem_stage: RTL
==============

# mem_stage

Memory-access pipeline stage sitting directly downstream of the ALU/EX-MEM pipeline register. It consumes that register's outputs (write/load/store flags, ALU result as address, store data, destination register). It drives a single-outstanding request/ready handshake to the data cache and stalls upstream while a cache access is pending. It registers the result into the MEM/WB outputs for register writeback.

## Interface
- `ADDR_W`, 32, data-cache address width
- `DATA_W`, 32, data word width
- `REG_ADDR_W`, 5, destination register index width
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `is_write_in`, `is_load_in`, `is_store_in` in 1 each: instruction flags from the EX-MEM register
- `alu_result_in` in `ADDR_W`: ALU result, used as the memory address for loads and stores
- `store_data_in` in `DATA_W`: store data
- `register_d_in` in `REG_ADDR_W`: destination register
- `stall_out` out 1: freezes upstream stages while high
- `dc_req` out 1: cache request valid
- `dc_we` out 1: 1 for store, 0 for load
- `dc_addr` out `ADDR_W`: request address
- `dc_wdata` out `DATA_W`: store data
- `dc_ready` in 1: cache completes the request this cycle
- `dc_rdata` in `DATA_W`: load data, valid when `dc_ready` is high
- `wb_is_write_out` out 1: register-file write enable
- `wb_register_d_out` out `REG_ADDR_W`: write index
- `wb_data_out` out `DATA_W`: write data
- `misaligned_out` out 1: one-cycle misaligned-access pulse (see Configuration)

## Operation
- FSM has two states, IDLE and REQ.
- **IDLE**
  - A memory op is present when `is_load_in | is_store_in`. If `is_store_in` is high, the op is a store; `is_load_in` is ignored.
  - On a memory op: capture address, store data, `dc_we`, `register_d_in`, and `is_write_in` into request registers. Go to REQ. `stall_out` is 1 in this cycle.
  - On a non-memory op: `wb_is_write_out <= is_write_in`, `wb_data_out <= alu_result_in`, `wb_register_d_out <= register_d_in`.
- **REQ**
  - `dc_req` is 1. `dc_addr`, `dc_wdata`, and `dc_we` come from the request registers and hold stable until `dc_ready`.
  - `stall_out` is `!dc_ready`.
  - On `dc_ready`, return to IDLE and write the WB outputs:
    - Load: `wb_data_out <= dc_rdata`, `wb_is_write_out <= latched is_write`.
    - Store: `wb_is_write_out <= 0`.
- A bubble is written (`wb_is_write_out <= 0`) on every cycle that produces no completion: the IDLE capture cycle and REQ cycles without `dc_ready`.
- A write to register 0 is always suppressed: `wb_is_write_out` is forced to 0 when the destination index is 0.
- Inputs are sampled only in IDLE. Upstream holds the instruction during stall, but it is never re-issued.
- Reset (`reset` low) forces:
  - state to IDLE
  - `dc_req`, `dc_we`, `stall_out`, `misaligned_out` to 0
  - all `wb_*` outputs to 0
  - `dc_addr`, `dc_wdata`, and the request registers to 0

  This happens immediately and asynchronously, including mid-REQ. An aborted request is dropped, not retried.

## Timing
- `dc_req`, `dc_we`, `dc_addr`, `dc_wdata`, `misaligned_out`, and `wb_*` are driven from registers.
- `stall_out` is combinational from state, the input flags, and `dc_ready`.
- Non-memory op at edge N: WB outputs valid after edge N+1. `stall_out` stays 0.
- Memory op whose cache accepts it in the k-th REQ cycle (k ≥ 1):
  - `stall_out` is high for k cycles (the IDLE cycle plus k−1 REQ cycles).
  - `dc_req` is high for k cycles.
  - WB outputs are valid the cycle after `dc_ready`.
- Minimum memory-op occupancy is 2 cycles. Back-to-back memory ops issue without an extra idle cycle.

## Configuration
- Macro: `MEM_STAGE_ALIGN_CHECK_EN`.
- Defined: a memory op in IDLE with `alu_result_in[1:0] != 0` does the following:
  - captures nothing and issues no request
  - does not stall
  - pulses `misaligned_out` high for one cycle
  - writes a WB bubble
- Undefined:
  - no alignment check is made
  - the full address, low bits included, is passed to `dc_addr`
  - `misaligned_out` is tied to 0

## Structure
- A shared pipeline package holds:
  - the FSM state encoding localparams (IDLE, REQ)
  - the width defaults `ADDR_W`, `DATA_W`, `REG_ADDR_W`
- One sub-module, `mem_wb_register`, holds the WB output registers. It has an async active-low reset and a bubble/load/pass-through data select.

## Test plan
- **Reset:** `reset=0` mid-simulation → every output 0; after release, state is IDLE and `dc_req=0`.
- **ALU pass-through:** `is_write_in=1`, `register_d_in=5`, `alu_result_in=0x1234` → next cycle `wb_is_write_out=1`, `wb_register_d_out=5`, `wb_data_out=0x1234`. `stall_out` and `dc_req` stay 0.
- **Load hit:** load with addr `0x100`, rd=3, `dc_ready=1` in the first REQ cycle with `dc_rdata=0xDEADBEEF` → `stall_out` high 1 cycle, `dc_req` high 1 cycle with `dc_we=0`, then `wb_data_out=0xDEADBEEF`, `wb_register_d_out=3`, `wb_is_write_out=1`.
- **Store miss:** store with addr `0x200`, data `0xCAFE0001`, `dc_ready` in the 4th REQ cycle → `dc_req` high 4 cycles with stable addr/data and `dc_we=1`, `stall_out` high 4 cycles, `wb_is_write_out=0` throughout.
- **Reset mid-miss:** `reset` low during REQ → `dc_req` and `stall_out` drop without waiting for a clock edge. A load issued after release completes normally.
- **Edge cases:**
  - A load to rd=0 → `wb_is_write_out=0`.
  - Macro on, load at `0x102` → `misaligned_out` pulses 1 cycle, `dc_req` never asserts.
  - Macro off, load at `0x102` → `dc_addr=0x102`.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: width defaults,
// FSM state encoding and the writeback data-select encoding.
package mem_stage_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      WB_BUBBLE = 2'd0,
      WB_PASS   = 2'd1,
      WB_LOAD   = 2'd2
   } wb_sel_t;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB output registers: bubble, ALU pass-through or load-data select.
// Writes to register 0 are suppressed here so every path gets the same rule.
module mem_wb_register
   import mem_stage_pkg::*;
#(
   parameter int DATA_W     = mem_stage_pkg::DATA_W,
   parameter int REG_ADDR_W = mem_stage_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  wb_sel_t               i_sel,
   input  logic                  i_is_write,
   input  logic [REG_ADDR_W-1:0] i_reg_d,
   input  logic [DATA_W-1:0]     i_alu_data,
   input  logic [DATA_W-1:0]     i_load_data,
   output logic                  o_is_write,
   output logic [REG_ADDR_W-1:0] o_reg_d,
   output logic [DATA_W-1:0]     o_data
);

   logic w_we_ok;
   assign w_we_ok = i_is_write && (i_reg_d != '0);

   // A bubble only drops the write enable; index and data keep their last value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_is_write <= 1'b0;
         o_reg_d    <= '0;
         o_data     <= '0;
      end else begin
         case (i_sel)
            WB_PASS: begin
               o_is_write <= w_we_ok;
               o_reg_d    <= i_reg_d;
               o_data     <= i_alu_data;
            end
            WB_LOAD: begin
               o_is_write <= w_we_ok;
               o_reg_d    <= i_reg_d;
               o_data     <= i_load_data;
            end
            default: o_is_write <= 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding data-cache handshake, upstream stall,
// MEM/WB result registers. Optional alignment check: MEM_STAGE_ALIGN_CHECK_EN.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W     = mem_stage_pkg::ADDR_W,
   parameter int DATA_W     = mem_stage_pkg::DATA_W,
   parameter int REG_ADDR_W = mem_stage_pkg::REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  is_write_in,
   input  logic                  is_load_in,
   input  logic                  is_store_in,
   input  logic [ADDR_W-1:0]     alu_result_in,
   input  logic [DATA_W-1:0]     store_data_in,
   input  logic [REG_ADDR_W-1:0] register_d_in,
   output logic                  stall_out,
   output logic                  dc_req,
   output logic                  dc_we,
   output logic [ADDR_W-1:0]     dc_addr,
   output logic [DATA_W-1:0]     dc_wdata,
   input  logic                  dc_ready,
   input  logic [DATA_W-1:0]     dc_rdata,
   output logic                  wb_is_write_out,
   output logic [REG_ADDR_W-1:0] wb_register_d_out,
   output logic [DATA_W-1:0]     wb_data_out,
   output logic                  misaligned_out
);

   state_t                r_state, w_state_nxt;
   logic                  r_dc_req, r_we, r_is_write, r_misaligned;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic [REG_ADDR_W-1:0] r_rd;
   logic                  w_is_mem, w_misalign, w_issue, w_stall;
   wb_sel_t               w_wb_sel;
   logic                  w_wb_is_write;
   logic [REG_ADDR_W-1:0] w_wb_rd;

   assign w_is_mem = is_load_in | is_store_in;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
   assign w_misalign = w_is_mem && (alu_result_in[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif
   assign w_issue = w_is_mem && !w_misalign;

   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_wb_sel    = WB_BUBBLE;
      case (r_state)
         IDLE: begin
            if (w_issue) begin
               w_state_nxt = REQ;
               w_stall     = 1'b1;
            end else if (!w_is_mem) begin
               w_wb_sel = WB_PASS;
            end
         end
         REQ: begin
            w_stall = !dc_ready;
            if (dc_ready) begin
               w_state_nxt = IDLE;
               w_wb_sel    = r_we ? WB_BUBBLE : WB_LOAD;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Reset must drop the stall immediately even with a memory op on the inputs.
   assign stall_out = reset && w_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_dc_req     <= 1'b0;
         r_we         <= 1'b0;
         r_is_write   <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rd         <= '0;
         r_misaligned <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_misaligned <= (r_state == IDLE) && w_misalign;
         if (r_state == IDLE && w_issue) begin
            r_dc_req   <= 1'b1;
            r_we       <= is_store_in;
            r_is_write <= is_write_in;
            r_addr     <= alu_result_in;
            r_wdata    <= store_data_in;
            r_rd       <= register_d_in;
         end else if (r_state == REQ && dc_ready) begin
            r_dc_req <= 1'b0;
         end
      end
   end

   assign dc_req         = r_dc_req;
   assign dc_we          = r_we;
   assign dc_addr        = r_addr;
   assign dc_wdata       = r_wdata;
   assign misaligned_out = r_misaligned;

   assign w_wb_is_write = (r_state == REQ) ? r_is_write : is_write_in;
   assign w_wb_rd       = (r_state == REQ) ? r_rd : register_d_in;

   mem_wb_register #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_wb (
      .clk         (clk),
      .reset       (reset),
      .i_sel       (w_wb_sel),
      .i_is_write  (w_wb_is_write),
      .i_reg_d     (w_wb_rd),
      .i_alu_data  (alu_result_in),
      .i_load_data (dc_rdata),
      .o_is_write  (wb_is_write_out),
      .o_reg_d     (wb_register_d_out),
      .o_data      (wb_data_out)
   );

endmodule
